// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath control bundle
interface multicycle_ctrl_if;
  logic [31:0] instruction;
  logic        zero;
  logic [3:0]  ALUctr;
  logic [1:0]  ExtOp;
  logic        ALUsrc;
  logic        RegDst;
  logic        MemtoReg;
  logic        RegWr;
  logic        MemWr;
  logic        Branch;
  logic        jump;
  logic        PCWr;
  logic        IRWr;

  // Controller side: reads IR and flags, drives every control line.
  modport master (
    input  instruction, zero,
    output ALUctr, ExtOp, ALUsrc, RegDst, MemtoReg,
    output RegWr, MemWr, Branch, jump, PCWr, IRWr
  );

  // Datapath side: supplies IR and flags, consumes control lines.
  modport slave (
    output instruction, zero,
    input  ALUctr, ExtOp, ALUsrc, RegDst, MemtoReg,
    input  RegWr, MemWr, Branch, jump, PCWr, IRWr
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with run/halt and retire counter
module multicycle_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  multicycle_ctrl_if.master    io,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] ir_q;      // {opcode, funct} captured at the end of ID
  logic [5:0]  op, fn;
  logic        is_r, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic        r_ok, legal;
  logic [3:0]  r_ctr;
  logic        unused_bits;

  // Only opcode/funct matter here; zero feeds NPC directly.
  assign unused_bits = ^{io.zero, io.instruction[25:6]};

  // In ID the freshly loaded IR is decoded live; afterwards the captured copy
  // is used so IR changes mid-instruction cannot disturb the control lines.
  assign op = (state_q == S_ID) ? io.instruction[31:26] : ir_q[11:6];
  assign fn = (state_q == S_ID) ? io.instruction[5:0]   : ir_q[5:0];

  // Instruction decode
  always_comb begin
    is_r   = (op == 6'b000000);
    is_ori = (op == 6'b001101);
    is_lui = (op == 6'b001111);
    is_lw  = (op == 6'b100011);
    is_sw  = (op == 6'b101011);
    is_beq = (op == 6'b000100);
    is_j   = (op == 6'b000010);
    r_ok   = 1'b1;
    r_ctr  = 4'b0000;
    case (fn)
      6'b100001: r_ctr = 4'b0000;
      6'b100011: r_ctr = 4'b0001;
      6'b100100: r_ctr = 4'b0010;
      6'b100101: r_ctr = 4'b0011;
      6'b101010: r_ctr = 4'b0100;
      default:   r_ok  = 1'b0;
    endcase
    legal = (is_r && r_ok) || is_ori || is_lui || is_lw || is_sw || is_beq || is_j;
  end

  // Next-state and control outputs; reset forces every output low
  always_comb begin
    state_d     = state_q;
    io.ALUctr   = 4'b0000;
    io.ExtOp    = 2'b00;
    io.ALUsrc   = 1'b0;
    io.RegDst   = 1'b0;
    io.MemtoReg = 1'b0;
    io.RegWr    = 1'b0;
    io.MemWr    = 1'b0;
    io.Branch   = 1'b0;
    io.jump     = 1'b0;
    io.PCWr     = 1'b0;
    io.IRWr     = 1'b0;
    halted      = 1'b0;

    // Static decode is held from EX until the instruction retires.
    if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      if (is_r) begin
        io.RegDst = 1'b1;
        io.ALUctr = r_ctr;
      end else if (is_ori) begin
        io.ALUsrc = 1'b1;
        io.ALUctr = 4'b0011;
      end else if (is_lui) begin
        io.ExtOp  = 2'b10;
        io.ALUsrc = 1'b1;
      end else if (is_lw || is_sw) begin
        io.ExtOp    = 2'b01;
        io.ALUsrc   = 1'b1;
        io.MemtoReg = is_lw;
      end else if (is_beq) begin
        io.ExtOp  = 2'b01;
        io.ALUctr = 4'b0001;
      end
    end

    case (state_q)
      S_IF: begin
        if (run) begin
          io.IRWr = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (is_j) begin
          io.jump = 1'b1;
          io.PCWr = 1'b1;
          state_d = S_IF;
        end else if (!legal) begin
          if (HALT_ON_ILLEGAL) begin
            state_d = S_HALT;
          end else begin
            io.PCWr = 1'b1;
            state_d = S_IF;
          end
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_beq) begin
          io.Branch = 1'b1;
          io.PCWr   = 1'b1;
          state_d   = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          io.MemWr = 1'b1;
          io.PCWr  = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        io.RegWr = 1'b1;
        io.PCWr  = 1'b1;
        state_d  = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IF;
    endcase

    if (rst) begin
      io.ALUctr   = 4'b0000;
      io.ExtOp    = 2'b00;
      io.ALUsrc   = 1'b0;
      io.RegDst   = 1'b0;
      io.MemtoReg = 1'b0;
      io.RegWr    = 1'b0;
      io.MemWr    = 1'b0;
      io.Branch   = 1'b0;
      io.jump     = 1'b0;
      io.PCWr     = 1'b0;
      io.IRWr     = 1'b0;
      halted      = 1'b0;
    end
  end

  // State register, IR decode capture and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      ir_q    <= 12'd0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) ir_q <= {io.instruction[31:26], io.instruction[5:0]};
      if (io.PCWr) retired <= retired + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, rst1, run1;
  logic        halted0, halted1;
  logic [2:0]  st0, st1;
  logic [31:0] ret0;
  logic [3:0]  ret1;

  multicycle_ctrl_if bus0();
  multicycle_ctrl_if bus1();

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .run(run), .io(bus0),
    .halted(halted0), .state(st0), .retired(ret0)
  );

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .run(run1), .io(bus1),
    .halted(halted1), .state(st1), .retired(ret1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    int          lat;
    logic [3:0]  aluctr;
    logic [1:0]  extop;
    logic        alusrc, regdst, memtoreg;
    int          nreg, nmem, nbr, nj;
    logic [31:0] ret;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] sb_ret = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: measures each instruction from IRWr to PCWr and scores it
  int lat = 0, nreg = 0, nmem = 0, nbr = 0, nj = 0;
  bit busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy = 1'b0;
    end else begin
      if (bus0.IRWr) begin
        busy = 1'b1; lat = 0; nreg = 0; nmem = 0; nbr = 0; nj = 0;
      end
      if (busy) begin
        lat++;
        nreg += int'(bus0.RegWr);
        nmem += int'(bus0.MemWr);
        nbr  += int'(bus0.Branch);
        nj   += int'(bus0.jump);
      end
      if (bus0.RegWr && bus0.MemWr) check("regwr_memwr_exclusive", 32'd1, 32'd0);
      if (bus0.PCWr) begin
        if (sbq.size() == 0) begin
          check("unexpected_pcwr", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          $display("retire instr=%h lat=%0d", e.instr, lat);
          check("latency",  32'(lat),  32'(e.lat));
          check("ALUctr",   32'(bus0.ALUctr), 32'(e.aluctr));
          check("ExtOp",    32'(bus0.ExtOp),  32'(e.extop));
          check("muxsel",   {29'd0, bus0.ALUsrc, bus0.RegDst, bus0.MemtoReg},
                            {29'd0, e.alusrc, e.regdst, e.memtoreg});
          check("strobe_counts", {nreg[7:0], nmem[7:0], nbr[7:0], nj[7:0]},
                                 {e.nreg[7:0], e.nmem[7:0], e.nbr[7:0], e.nj[7:0]});
          check("retired_pre", ret0, e.ret);
        end
        busy = 1'b0;
      end
    end
  end

  task automatic wait_if();
    bit ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (st0 == 3'd0) begin ok = 1'b1; break; end
    end
    if (!ok) check("wait_if_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [31:0] instr, input logic z, input int lt,
                       input logic [3:0] actr, input logic [1:0] ext,
                       input logic asrc, input logic rdst, input logic m2r,
                       input int er, input int em, input int eb, input int ej);
    exp_t e;
    bit got = 1'b0;
    e.instr = instr; e.lat = lt; e.aluctr = actr; e.extop = ext;
    e.alusrc = asrc; e.regdst = rdst; e.memtoreg = m2r;
    e.nreg = er; e.nmem = em; e.nbr = eb; e.nj = ej; e.ret = sb_ret;
    wait_if();
    sbq.push_back(e);
    sb_ret = sb_ret + 32'd1;
    bus0.instruction = instr;
    bus0.zero = z;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      // Scribble over IR once past ID: decode must use the captured copy.
      if (st0 >= 3'd2 && st0 != 3'd5) bus0.instruction = 32'hFFFF_FFFF;
      if (bus0.PCWr) begin got = 1'b1; break; end
    end
    if (!got) check("retire_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; run = 1'b0; rst1 = 1'b1; run1 = 1'b0;
    bus0.instruction = 32'd0; bus0.zero = 1'b0;
    bus1.instruction = 32'd0; bus1.zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(st0), 32'd0);
    check("reset_retired", ret0, 32'd0);
    check("reset_strobes", {26'd0, bus0.RegWr, bus0.MemWr, bus0.Branch, bus0.jump, bus0.PCWr, bus0.IRWr}, 32'd0);
    check("reset_halted", 32'(halted0), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // run=0 holds the FSM in IF
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_irwr_pcwr", {30'd0, bus0.IRWr, bus0.PCWr}, 32'd0);
      check("idle_state", 32'(st0), 32'd0);
      check("idle_retired", ret0, 32'd0);
    end

    //     instr         z     lat ALUctr   ExtOp  src  dst  m2r  reg mem br j
    issue(32'h00221821, 1'b0, 4, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0); // addu
    issue(32'h8C040008, 1'b0, 5, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0); // lw
    issue(32'hAC040008, 1'b0, 4, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0, 0, 1, 0, 0); // sw
    issue(32'h10000003, 1'b1, 3, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0); // beq taken
    issue(32'h10000003, 1'b0, 3, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0); // beq not taken
    issue(32'h08000004, 1'b0, 2, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1); // j
    issue(32'h00221823, 1'b0, 4, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0); // subu
    issue(32'h00221824, 1'b0, 4, 4'b0010, 2'b00, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0); // and
    issue(32'h00221825, 1'b0, 4, 4'b0011, 2'b00, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0); // or
    issue(32'h0022182A, 1'b0, 4, 4'b0100, 2'b00, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0); // slt
    issue(32'h342300FF, 1'b0, 4, 4'b0011, 2'b00, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0); // ori
    issue(32'h3C031234, 1'b0, 4, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0); // lui

    // Reset in MEM of a store cancels it
    wait_if();
    bus0.instruction = 32'hAC040008;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (st0 == 3'd3) begin ok = 1'b1; rst = 1'b1; break; end
    end
    check("reach_mem", 32'(ok), 32'd1);
    @(posedge clk); #1 run = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(st0), 32'd0);
    check("midrst_memwr_pcwr", {30'd0, bus0.MemWr, bus0.PCWr}, 32'd0);
    check("midrst_retired", ret0, 32'd0);
    sb_ret = 32'd0;

    // Illegal opcode halts
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b1; bus0.instruction = 32'hFC000000;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (st0 == 3'd5) begin ok = 1'b1; break; end
    end
    check("reach_halt", 32'(ok), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("halt_state", 32'(st0), 32'd5);
      check("halt_flag", 32'(halted0), 32'd1);
      check("halt_strobes", {26'd0, bus0.RegWr, bus0.MemWr, bus0.Branch, bus0.jump, bus0.PCWr, bus0.IRWr}, 32'd0);
      @(negedge clk);
    end
    check("halt_retired", ret0, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 begin rst = 1'b0; run = 1'b0; end
    @(negedge clk);
    check("unhalt_state", 32'(st0), 32'd0);
    check("unhalt_flag", 32'(halted0), 32'd0);
    check("unhalt_retired", ret0, 32'd0);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    // Illegal-as-NOP with a 4-bit counter: wrap 15 -> 0
    @(posedge clk); #1;
    rst1 = 1'b0; run1 = 1'b1; bus1.instruction = 32'hFC000000;
    for (int k = 0; k < 16; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (bus1.PCWr) begin ok = 1'b1; break; end
      end
      check("nop_retire", 32'(ok), 32'd1);
      check("nop_count", 32'(ret1), k);
      check("nop_not_halted", 32'(halted1), 32'd0);
    end
    @(negedge clk);
    check("nop_wrap", 32'(ret1), 32'd0);
    run1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the MIPS datapath (PC, NPC, IM, REGFILE, EXT, ALU, DM). It runs one instruction over 2–5 states (IF/ID/EX/MEM/WB) instead of one cycle.
- Drives every datapath control line, plus PC and IR write enables.
- Decodes the latched instruction; adds run/halt gating and a retired-instruction counter.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an illegal opcode/funct enters HALT; 0: it retires as a NOP.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock; every state and register updates on the rising edge
rst  input  1  reset, synchronous, active-high
run  input  1  1 = fetch allowed; sampled only in IF
instruction  input  32  current IR contents (opcode [31:26], funct [5:0])
zero  input  1  ALU zero flag
ALUctr  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt
ExtOp  output  2  00 zero-extend, 01 sign-extend, 10 imm16<<16
ALUsrc, RegDst, MemtoReg  output  1 each  datapath mux selects
RegWr, MemWr, Branch, jump  output  1 each  datapath strobes
PCWr  output  1  PC update enable
IRWr  output  1  IR load enable
halted  output  1  FSM is in HALT
state  output  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (rst=1 at a clock edge): next state is IF; all outputs 0; retired=0. Reset overrides every state, including mid-instruction and HALT.
- Supported instructions; anything else is illegal:
  - R-type (op 000000), by funct: addu 100001, subu 100011, and 100100, or 100101, slt 101010.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
- Static decode, held constant from EX until the instruction retires:
  - R-type: RegDst=1, ALUsrc=0, ALUctr per funct.
  - ori: ExtOp=00, ALUsrc=1, ALUctr=or.
  - lui: ExtOp=10, ALUsrc=1, ALUctr=add (rs=$0).
  - lw/sw: ExtOp=01, ALUsrc=1, add; lw additionally MemtoReg=1.
  - beq: ExtOp=01, ALUsrc=0, sub.
- Strobes (RegWr, MemWr, Branch, jump, PCWr, IRWr) are high for exactly one cycle, only in the state listed below.
- IF:
  - run=1: IRWr=1, go to ID.
  - run=0: stay in IF; all strobes 0.
- ID:
  - j: jump=1, PCWr=1, retire, go to IF.
  - Illegal with HALT_ON_ILLEGAL=1: go to HALT; no PCWr.
  - Illegal with HALT_ON_ILLEGAL=0: PCWr=1, retire, go to IF.
  - Otherwise go to EX.
- EX:
  - beq: Branch=1, PCWr=1, retire, go to IF. NPC selects the target using zero, so taken and not-taken cost the same.
  - lw/sw: go to MEM.
  - R-type/ori/lui: go to WB.
- MEM:
  - sw: MemWr=1, PCWr=1, retire, go to IF.
  - lw: go to WB.
- WB: RegWr=1, PCWr=1, retire, go to IF.
- HALT: all strobes 0, halted=1. Exits only through rst.
- Latency in cycles:
  - j / illegal-NOP: 2
  - beq: 3
  - sw, R-type/ori/lui: 4
  - lw: 5
- Retire: retired increments by 1 in the same cycle as PCWr (registered, visible next cycle). Wraps from 2^CNT_W-1 to 0.
- Invariants:
  - PCWr is asserted exactly once per retired instruction.
  - RegWr and MemWr are never high in the same cycle.
  - Decode uses instruction as held in IR; changes on instruction outside IF/ID are ignored until the next IRWr.

Test Plan:
- Reset: rst=1 then run=1, IR=addu $3,$1,$2 (0x00221821) -> state 0,1,2,4; RegWr=1 and PCWr=1 only in cycle 4; RegDst=1, ALUctr=0000; retired=1.
- lw $4,8($0) (0x8C040008) -> 5 cycles; ExtOp=01, ALUsrc=1, MemtoReg=1; RegWr only in WB; MemWr never high.
- sw / beq / j:
  - sw (0xAC040008) -> MemWr=1 for exactly 1 cycle, in MEM, with PCWr.
  - beq with zero=1, then zero=0 -> 3 cycles each, Branch=PCWr=1 in EX.
  - j (0x08000004) -> 2 cycles, jump=1 in ID.
- Illegal op 0x3F, HALT_ON_ILLEGAL=1 -> state 5, halted=1, no strobes for 20 cycles; rst=1 -> IF, halted=0, retired=0.
- run=0 held 10 cycles in IF -> no IRWr/PCWr and retired unchanged; run=1 -> IRWr next cycle.
- rst asserted in MEM of sw -> next cycle state=IF, MemWr=0, PCWr=0, retired=0.
- CNT_W=4, 16 NOPs (HALT_ON_ILLEGAL=0) -> retired wraps 15 -> 0.
